// File: rtl/ceespu_store_buffer_if.sv
// ceespu_store_buffer_if
//   Store-buffer bus: execute-stage store requests on one side and the
//   data-memory write channel on the other.
//   master : execute stage + data memory (drives requests and acks)
//   slave  : the store buffer
//   I_valid/I_selMem/I_addr/I_data  store request
//   I_mem_ack                       memory accepted head write
//   O_busy/O_empty                  full / drained status
//   O_mem_req/addr/wdata/wmask      head-entry write to memory
//   O_done                          one-cycle pulse per completed write
interface ceespu_store_buffer_if;
  logic        I_valid;
  logic [3:0]  I_selMem;
  logic [13:0] I_addr;
  logic [31:0] I_data;
  logic        I_mem_ack;
  logic        O_busy;
  logic        O_empty;
  logic        O_mem_req;
  logic [13:0] O_mem_addr;
  logic [31:0] O_mem_wdata;
  logic [3:0]  O_mem_wmask;
  logic        O_done;

  modport master (
    output I_valid, I_selMem, I_addr, I_data, I_mem_ack,
    input  O_busy, O_empty, O_mem_req, O_mem_addr, O_mem_wdata, O_mem_wmask, O_done
  );

  modport slave (
    input  I_valid, I_selMem, I_addr, I_data, I_mem_ack,
    output O_busy, O_empty, O_mem_req, O_mem_addr, O_mem_wdata, O_mem_wmask, O_done
  );
endinterface

// File: rtl/ceespu_store_buffer.sv
// ceespu_store_buffer
//   Two-entry store FIFO between execute and data memory. Stores are
//   lane-encoded on acceptance and drained in order, one memory write per
//   ack, back-to-back when more entries are pending.
//   I_clk  : clock, rising edge
//   I_rst  : synchronous reset, active low
//   bus    : ceespu_store_buffer_if.slave (request, status, memory channel)
module ceespu_store_buffer (
  input  logic                        I_clk,
  input  logic                        I_rst,
  ceespu_store_buffer_if.slave        bus
);

  typedef enum logic {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

  // Entry layout: {addr[13:0], wdata[31:0], mask[3:0]}
  logic [49:0] r_mem [2];
  logic [1:0]  r_count;
  logic        r_wptr;
  logic        r_rptr;
  state_t      r_state;
  logic        r_done;

  logic [31:0] w_enc_wdata;
  logic [3:0]  w_enc_mask;
  logic        w_push;
  logic        w_pop;
  logic [1:0]  w_count_nxt;
  logic [49:0] w_head;

  // Lane encode: payloads are replicated across lanes so memory only
  // needs the byte enables to pick the right bytes.
  always_comb begin
    w_enc_wdata = bus.I_data;
    w_enc_mask  = 4'b1111;
    case (bus.I_selMem[2:0])
      3'b000, 3'b001: begin
        w_enc_wdata = bus.I_data;
        w_enc_mask  = 4'b1111;
      end
      3'b010: begin
        w_enc_wdata = {bus.I_data[15:0], bus.I_data[15:0]};
        w_enc_mask  = 4'b0011;
      end
      3'b011: begin
        w_enc_wdata = {bus.I_data[15:0], bus.I_data[15:0]};
        w_enc_mask  = 4'b1100;
      end
      default: begin
        w_enc_wdata = {4{bus.I_data[7:0]}};
        w_enc_mask  = 4'b0001 << bus.I_selMem[1:0];
      end
    endcase
  end

  // A full buffer never accepts, even if the head pops on the same edge.
  assign w_push      = bus.I_valid && (r_count != 2'd2);
  assign w_pop       = (r_state == ST_REQ) && bus.I_mem_ack;
  assign w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
  assign w_head      = r_mem[r_rptr];

  always_ff @(posedge I_clk) begin
    if (!I_rst) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      // REQ whenever anything is pending after this edge: covers the
      // accepting edge and back-to-back drain without an idle bubble.
      r_state <= (w_count_nxt != 2'd0) ? ST_REQ : ST_IDLE;
      r_done  <= w_pop;
    end
  end

  // Entry storage needs no reset; only slots behind the count are read.
  always_ff @(posedge I_clk) begin
    if (I_rst && w_push) r_mem[r_wptr] <= {bus.I_addr, w_enc_wdata, w_enc_mask};
  end

  assign bus.O_busy      = (r_count == 2'd2);
  assign bus.O_empty     = (r_count == 2'd0);
  assign bus.O_mem_req   = (r_state == ST_REQ);
  assign bus.O_mem_addr  = (r_state == ST_REQ) ? w_head[49:36] : 14'd0;
  assign bus.O_mem_wdata = (r_state == ST_REQ) ? w_head[35:4]  : 32'd0;
  assign bus.O_mem_wmask = (r_state == ST_REQ) ? w_head[3:0]   : 4'd0;
  assign bus.O_done      = r_done;

endmodule

// File: tb/tb_ceespu_store_buffer.sv
module tb_ceespu_store_buffer;

  logic I_clk = 1'b0;
  logic I_rst;
  ceespu_store_buffer_if bus();

  ceespu_store_buffer dut (.I_clk(I_clk), .I_rst(I_rst), .bus(bus));

  always #5 I_clk = ~I_clk;

  typedef struct {
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } ent_t;

  ent_t q[$];
  logic m_done;
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic ent_t encode(logic [3:0] sel, logic [13:0] a, logic [31:0] d);
    ent_t e;
    e.addr = a;
    case (sel[2:0])
      3'b010:  begin e.wdata = {d[15:0], d[15:0]}; e.mask = 4'b0011; end
      3'b011:  begin e.wdata = {d[15:0], d[15:0]}; e.mask = 4'b1100; end
      3'b100:  begin e.wdata = {4{d[7:0]}}; e.mask = 4'b0001; end
      3'b101:  begin e.wdata = {4{d[7:0]}}; e.mask = 4'b0010; end
      3'b110:  begin e.wdata = {4{d[7:0]}}; e.mask = 4'b0100; end
      3'b111:  begin e.wdata = {4{d[7:0]}}; e.mask = 4'b1000; end
      default: begin e.wdata = d; e.mask = 4'b1111; end
    endcase
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of up to two encoded stores.
  task automatic model_edge();
    bit push, pop;
    if (!I_rst) begin
      q.delete();
      m_done = 1'b0;
    end else begin
      push = bus.I_valid && (q.size() < 2);
      pop  = bus.I_mem_ack && (q.size() > 0);
      m_done = pop;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(encode(bus.I_selMem, bus.I_addr, bus.I_data));
    end
  endtask

  task automatic compare_model();
    bit   ne = (q.size() != 0);
    ent_t h;
    h.addr = 14'd0; h.wdata = 32'd0; h.mask = 4'd0;
    if (ne) h = q[0];
    chk("busy",  {31'd0, bus.O_busy},    {31'd0, q.size() == 2});
    chk("empty", {31'd0, bus.O_empty},   {31'd0, q.size() == 0});
    chk("req",   {31'd0, bus.O_mem_req}, {31'd0, ne});
    chk("addr",  {18'd0, bus.O_mem_addr}, {18'd0, h.addr});
    chk("wdata", bus.O_mem_wdata, h.wdata);
    chk("wmask", {28'd0, bus.O_mem_wmask}, {28'd0, h.mask});
    chk("done",  {31'd0, bus.O_done},    {31'd0, m_done});
  endtask

  // Inputs are changed at the falling edge; outputs checked there too.
  task automatic step();
    @(posedge I_clk);
    model_edge();
    @(negedge I_clk);
    compare_model();
  endtask

  task automatic drive(bit v, logic [3:0] s, logic [13:0] a, logic [31:0] d, bit ack);
    bus.I_valid = v; bus.I_selMem = s; bus.I_addr = a; bus.I_data = d; bus.I_mem_ack = ack;
  endtask

  initial begin
    m_done = 1'b0;
    I_rst = 1'b0;
    drive(1, 4'b0000, 14'h3ff, 32'h11111111, 1);   // valid during reset ignored
    step(); step();
    chk("rst_empty", {31'd0, bus.O_empty}, 32'd1);
    chk("rst_req",   {31'd0, bus.O_mem_req}, 32'd0);
    chk("rst_addr",  {18'd0, bus.O_mem_addr}, 32'd0);
    I_rst = 1'b1;

    // Byte store, lane 2
    drive(1, 4'b0110, 14'h012, 32'h000000A5, 0); step();
    drive(0, 4'b0000, 14'h000, 32'h0, 0);
    chk("b_req",   {31'd0, bus.O_mem_req}, 32'd1);
    chk("b_wdata", bus.O_mem_wdata, 32'hA5A5A5A5);
    chk("b_mask",  {28'd0, bus.O_mem_wmask}, 32'h4);
    chk("b_addr",  {18'd0, bus.O_mem_addr}, 32'h012);
    bus.I_mem_ack = 1; step();
    chk("b_done",  {31'd0, bus.O_done}, 32'd1);
    bus.I_mem_ack = 0; step();
    chk("b_done_clr", {31'd0, bus.O_done}, 32'd0);

    // High halfword, then word
    drive(1, 4'b0011, 14'h020, 32'h1234BEEF, 0); step();
    drive(0, 4'b0000, 14'h000, 32'h0, 1);
    chk("h_wdata", bus.O_mem_wdata, 32'hBEEFBEEF);
    chk("h_mask",  {28'd0, bus.O_mem_wmask}, 32'hC);
    step();
    drive(1, 4'b0000, 14'h021, 32'hDEADBEEF, 0); step();
    drive(0, 4'b0000, 14'h000, 32'h0, 1);
    chk("w_wdata", bus.O_mem_wdata, 32'hDEADBEEF);
    chk("w_mask",  {28'd0, bus.O_mem_wmask}, 32'hF);
    step();
    bus.I_mem_ack = 0; step();

    // Three back-to-back stores with ack held low
    drive(1, 4'b0000, 14'h0A1, 32'h1, 0); step();
    drive(1, 4'b0000, 14'h0A2, 32'h2, 0); step();
    chk("bb_busy", {31'd0, bus.O_busy}, 32'd1);
    drive(1, 4'b0000, 14'h0A3, 32'h3, 0); step();
    chk("bb_hold", {18'd0, bus.O_mem_addr}, 32'h0A1);
    bus.I_mem_ack = 1; step();                  // full: A3 not taken this edge
    chk("bb_second", {18'd0, bus.O_mem_addr}, 32'h0A2);
    chk("bb_notfull", {31'd0, bus.O_busy}, 32'd0);
    bus.I_mem_ack = 0; step();                  // A3 taken now
    chk("bb_full2", {31'd0, bus.O_busy}, 32'd1);
    drive(0, 4'b0000, 14'h000, 32'h0, 1); step();
    chk("bb_third", {18'd0, bus.O_mem_addr}, 32'h0A3);
    step();
    chk("bb_drained", {31'd0, bus.O_empty}, 32'd1);
    bus.I_mem_ack = 0; step();

    // Two pending, ack held high
    drive(1, 4'b0000, 14'h0B1, 32'h5, 0); step();
    drive(1, 4'b0000, 14'h0B2, 32'h6, 0); step();
    drive(0, 4'b0000, 14'h000, 32'h0, 1); step();
    chk("ah_done1", {31'd0, bus.O_done}, 32'd1);
    chk("ah_req2",  {31'd0, bus.O_mem_req}, 32'd1);
    step();
    chk("ah_done2", {31'd0, bus.O_done}, 32'd1);
    chk("ah_empty", {31'd0, bus.O_empty}, 32'd1);
    chk("ah_noreq", {31'd0, bus.O_mem_req}, 32'd0);
    bus.I_mem_ack = 0; step();

    // Reset while requesting with two entries
    drive(1, 4'b0000, 14'h0C1, 32'h7, 0); step();
    drive(1, 4'b0000, 14'h0C2, 32'h8, 0); step();
    drive(0, 4'b0000, 14'h000, 32'h0, 1);
    I_rst = 0; step();
    chk("mr_empty", {31'd0, bus.O_empty}, 32'd1);
    chk("mr_noreq", {31'd0, bus.O_mem_req}, 32'd0);
    chk("mr_nodone", {31'd0, bus.O_done}, 32'd0);
    I_rst = 1; bus.I_mem_ack = 0; step();
    chk("mr_nodone2", {31'd0, bus.O_done}, 32'd0);
    drive(1, 4'b0101, 14'h0D0, 32'h0000005A, 0); step();
    drive(0, 4'b0000, 14'h000, 32'h0, 0);
    chk("mr_new_wdata", bus.O_mem_wdata, 32'h5A5A5A5A);
    chk("mr_new_mask", {28'd0, bus.O_mem_wmask}, 32'h2);
    bus.I_mem_ack = 1; step();
    bus.I_mem_ack = 0; step();

    // Ack pulsed while idle
    bus.I_mem_ack = 1; step();
    chk("idle_nodone", {31'd0, bus.O_done}, 32'd0);
    chk("idle_empty", {31'd0, bus.O_empty}, 32'd1);
    bus.I_mem_ack = 0; step();

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) < 60), 4'($urandom()), 14'($urandom()),
            $urandom(), ($urandom_range(0, 99) < 45));
      I_rst = ($urandom_range(0, 99) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ceespu_store_buffer.md
CEESPU_STORE_BUFFER -- requirements
Module: ceespu_store_buffer

Interface
REQ-001 SHALL: I_clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL: I_rst  input  1  synchronous, active-low reset (0 = reset), sampled on I_clk rising edge.
REQ-003 SHALL: I_valid  input  1  store request from execute stage.
REQ-004 SHALL: I_selMem  input  4  store size/lane select; bits [2:0] decoded; bit 3 ignored.
REQ-005 SHALL: I_addr  input  14  data-memory word address.
REQ-006 SHALL: I_data  input  32  register value to store; low bits carry halfword/byte payloads.
REQ-007 SHALL: I_mem_ack  input  1  memory accepted current write.
REQ-008 SHALL: O_busy  output  1  buffer full; execute stage stalls.
REQ-009 SHALL: O_empty  output  1  no stores pending (fence/drain indication).
REQ-010 SHALL: O_mem_req  output  1  write request to data memory.
REQ-011 SHALL: O_mem_addr  output  14  word address of head entry.
REQ-012 SHALL: O_mem_wdata  output  32  lane-replicated write data of head entry.
REQ-013 SHALL: O_mem_wmask  output  4  byte write enables of head entry; bit n = byte lane n (bits 8n+7:8n).
REQ-014 SHALL: O_done  output  1  one-cycle pulse per completed write.

Function
REQ-015 SHALL: lane encode on I_selMem[2:0]: 000/001 word -> wdata=I_data, mask 1111; 010 low half -> {I_data[15:0] x2}, mask 0011; 011 high half -> {I_data[15:0] x2}, mask 1100; 1nn byte nn -> I_data[7:0] replicated x4, mask = one-hot bit nn.
REQ-016 SHALL: encoding happens at acceptance; buffer entries store {addr, wdata, mask} (50 bits).
REQ-017 SHALL: buffer is a 2-entry FIFO with 2-bit count (0..2), write and read pointers wrapping 1 -> 0.
REQ-018 SHALL: store accepted on an edge where I_rst=1, I_valid=1, O_busy=0; otherwise I_valid ignored and nothing recorded.
REQ-019 SHALL: O_busy = (count == 2); O_empty = (count == 0); both combinational from registered count.
REQ-020 SHALL: full buffer accepts no store even if a pop occurs that same edge (no full-bypass).
REQ-021 SHALL: count=1 with push and pop on the same edge leaves count=1, pointers both advance.
REQ-022 SHALL: drain FSM states IDLE and REQ; O_mem_req = (state == REQ).
REQ-023 SHALL: IDLE -> REQ on any edge where count>0 after update (including the accepting edge); store accepted at edge N into empty buffer drives O_mem_req=1 in the cycle after edge N.
REQ-024 SHALL: in REQ, O_mem_addr/wdata/wmask reflect head entry and remain stable until an edge with I_mem_ack=1.
REQ-025 SHALL: I_mem_ack=1 in REQ at edge M pops head; O_done=1 for exactly the cycle after M.
REQ-026 SHALL: after pop, remain REQ presenting next entry if count>0 (back-to-back, no idle cycle); else go IDLE.
REQ-027 SHALL: I_mem_ack while IDLE ignored, no pop, no O_done.
REQ-028 SHALL: O_mem_addr/wdata/wmask drive 0 when IDLE.
REQ-029 SHALL: entries drain in strict acceptance order; no merging, no reordering.

Reset
REQ-030 SHALL: I_rst=0 at an edge sets count=0, both pointers=0, state IDLE, O_done=0; outputs then O_busy=0, O_empty=1, O_mem_req=0, addr/wdata/mask=0.
REQ-031 SHALL: reset mid-request discards all pending entries; I_mem_ack during that cycle ignored; no O_done follows.
REQ-032 SHALL: I_valid during reset not accepted.

Verification
REQ-033 SHALL: byte store selMem=0110, addr=0x012, data=0x000000A5, ack next cycle -> O_mem_req=1, wdata=0xA5A5A5A5, mask=0100, addr=0x012; O_done one cycle after ack.
REQ-034 SHALL: halfword selMem=0011, data=0x1234BEEF -> wdata=0xBEEFBEEF, mask=1100; word selMem=0000, data=0xDEADBEEF -> wdata=0xDEADBEEF, mask=1111.
REQ-035 SHALL: three back-to-back stores, ack held 0 -> first two accepted, O_busy=1, third held off until first ack; order of addresses on O_mem_addr matches acceptance.
REQ-036 SHALL: two stores pending, ack held 1 continuously -> two consecutive O_mem_req cycles, two O_done pulses, then O_empty=1, O_mem_req=0.
REQ-037 SHALL: reset asserted while O_mem_req=1 with 2 entries -> next cycle O_empty=1, O_mem_req=0, no O_done; new store afterwards issues normally.
REQ-038 SHALL: I_mem_ack pulsed while IDLE -> no O_done, count unchanged.
